// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// The state encoding is shared so that bench-side checkers can decode it.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = $clog2(DW_DEF);

  // Iteration counter width; never below one bit.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract
// the divisor if it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   partial,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   partial_next,
  output logic          qbit
);

  logic [VW:0] p;
  logic        unused_msb;

  // The partial is always below the divisor, so its top bit carries no data.
  assign unused_msb = partial[VW];
  assign p          = {partial[VW-1:0], din};

  always_comb begin
    qbit         = 1'b0;
    partial_next = p;
    if (p >= {1'b0, divisor}) begin
      qbit         = 1'b1;
      partial_next = p - {1'b0, divisor};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: start is sampled only in IDLE; done pulses for one cycle and the
// result outputs are valid from that cycle until the next done.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] work;    // dividend shifts out at the top, quotient in at the bottom
  logic [VW-1:0] dvs;
  logic [VW:0]   partial;
  logic [VW:0]   partial_next;
  logic          qbit;

  div_step #(.VW(VW)) u_step (
    .partial      (partial),
    .din          (work[DW-1]),
    .divisor      (dvs),
    .partial_next (partial_next),
    .qbit         (qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      dvs         <= '0;
      partial     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state   <= RUN;
              work    <= dividend;
              dvs     <= divisor;
              partial <= '0;
              cnt     <= CW'(DW - 1);
            end
          end
        end
        RUN: begin
          partial <= partial_next;
          work    <= {work[DW-2:0], qbit};
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            // Results are registered here so they are valid in the DONE cycle.
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= {work[DW-2:0], qbit};
            remainder   <= partial_next[VW-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: exhaustive div_step check, a vector table,
// hand-written multi-cycle corner cases and a randomised invariant sweep.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic [4:0] sp, snext;
  logic       sb, sq;
  logic [3:0] sd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  div_step #(.VW(4)) u_step (
    .partial      (sp),
    .din          (sb),
    .divisor      (sd),
    .partial_next (snext),
    .qbit         (sq)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts one division, optionally pulsing start (100/3) at RUN cycle inj,
  // and returns at the negedge of the done cycle. lat counts cycles after the
  // accepting edge (1 = cycle right after it); 0 means done never came.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv, input int inj,
                        output int lat, output logic busy1, output int hold_bad);
    logic [7:0] q0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat      = 0;
    busy1    = busy;
    q0       = quotient;
    hold_bad = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (done) lat = n;
      else begin
        if (quotient !== q0) hold_bad++;
        if (n == inj) begin
          start    = 1'b1;
          dividend = 8'd100;
          divisor  = 4'd3;
        end else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (lat == 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat, hold_bad, seen;
    logic       busy1;
    logic [7:0] rdd;
    logic [3:0] rdv;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    sp = '0; sb = 1'b0; sd = 4'd1;

    // Exhaustive single-step check over the reachable partial range.
    for (int dv = 1; dv < 16; dv++)
      for (int pr = 0; pr < dv; pr++)
        for (int b = 0; b < 2; b++) begin
          int p;
          sp = 5'(pr); sb = b[0]; sd = 4'(dv);
          #1;
          p = pr * 2 + b;
          check("step_qbit", int'(sq), (p >= dv) ? 1 : 0);
          check("step_partial", int'(snext), (p >= dv) ? p - dv : p);
        end

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    reset = 1'b0;

    vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9});
    vecs.push_back('{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9});
    vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9});
    vecs.push_back('{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9});
    vecs.push_back('{8'd42,  4'd0,  8'd255, 4'd0, 1'b1, 1});
    vecs.push_back('{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9});
    vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 9});
    vecs.push_back('{8'd7,   4'd7,  8'd1,   4'd0, 1'b0, 9});
    vecs.push_back('{8'd128, 4'd15, 8'd8,   4'd8, 1'b0, 9});
    vecs.push_back('{8'd1,   4'd15, 8'd0,   4'd1, 1'b0, 9});
    vecs.push_back('{8'd254, 4'd2,  8'd127, 4'd0, 1'b0, 9});
    vecs.push_back('{8'd0,   4'd0,  8'd255, 4'd0, 1'b1, 1});
    vecs.push_back('{8'd9,   4'd2,  8'd4,   4'd1, 1'b0, 9});

    foreach (vecs[i]) begin
      run_op(vecs[i].dd, vecs[i].dv, 0, lat, busy1, hold_bad);
      check("vec_busy_after_accept", int'(busy1), 1);
      check("vec_latency", lat, vecs[i].lat);
      check("vec_quotient", int'(quotient), int'(vecs[i].q));
      check("vec_remainder", int'(remainder), int'(vecs[i].r));
      check("vec_dbz", int'(div_by_zero), int'(vecs[i].z));
      check("vec_hold", hold_bad, 0);
      @(negedge clk);
      check("vec_done_one_cycle", int'(done), 0);
      check("vec_busy_cleared", int'(busy), 0);
      check("vec_result_held", int'(quotient), int'(vecs[i].q));
    end

    // start during RUN is ignored, then a back-to-back operation.
    run_op(8'd200, 4'd7, 3, lat, busy1, hold_bad);
    check("ign_latency", lat, 9);
    check("ign_quotient", int'(quotient), 28);
    check("ign_remainder", int'(remainder), 4);
    check("ign_hold", hold_bad, 0);
    run_op(8'd100, 4'd3, 0, lat, busy1, hold_bad);
    check("b2b_latency", lat, 9);
    check("b2b_quotient", int'(quotient), 33);
    check("b2b_remainder", int'(remainder), 1);

    // Reset in RUN cycle 4 aborts with no done pulse.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(8'd9, 4'd2, 0, lat, busy1, hold_bad);
    check("post_abort_latency", lat, 9);
    check("post_abort_quotient", int'(quotient), 4);
    check("post_abort_remainder", int'(remainder), 1);

    // Randomised invariant sweep.
    for (int i = 0; i < 1000; i++) begin
      rdd = 8'($urandom_range(0, 255));
      rdv = 4'($urandom_range(1, 15));
      run_op(rdd, rdv, 0, lat, busy1, hold_bad);
      check("rnd_invariant", int'(quotient) * int'(rdv) + int'(remainder), int'(rdd));
      check("rnd_rem_lt_div", (remainder < rdv) ? 1 : 0, 1);
      check("rnd_quotient", int'(quotient), int'(rdd) / int'(rdv));
      check("rnd_latency", lat, 9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
